// File: rtl/asteroid_collision_detect_pkg.sv
// Shared types and constants for the asteroid collision source.
// Coordinates are signed so sprite offsets may go negative.
package asteroid_collision_detect_pkg;

  localparam int COORD_W       = 11;
  localparam int OBJECT_WIDTH  = 32;
  localparam int OBJECT_HEIGHT = 32;
  localparam int EDGE_MARGIN   = 4;
  localparam int COUNT_WIDTH   = 8;

  typedef logic signed [COORD_W-1:0] coord_t;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] REPORT  = 1'b1;

  typedef struct packed {
    logic       p;
    logic       m;
    logic       b;
    logic [3:0] e;
  } hit_t;

endpackage

// File: rtl/asteroid_edge_classifier.sv
// Maps a pixel offset inside a sprite to a side code.
// Bits: [3]left [2]top [1]right [0]bottom; corners set two.
module asteroid_edge_classifier
  import asteroid_collision_detect_pkg::*;
#(
  parameter int W = OBJECT_WIDTH,
  parameter int H = OBJECT_HEIGHT,
  parameter int M = EDGE_MARGIN
) (
  input  coord_t     offX_i,
  input  coord_t     offY_i,
  output logic [3:0] edge_o
);

  int ox;
  int oy;

  // signed compare of offsets against the side bands
  always_comb begin
    ox        = int'(offX_i);
    oy        = int'(offY_i);
    edge_o[3] = ox < M;
    edge_o[2] = oy < M;
    edge_o[1] = ox >= (W - M);
    edge_o[0] = oy >= (H - M);
  end

endmodule

// File: rtl/asteroid_collision_detect.sv
// Per-asteroid collision source: collects overlaps over a
// frame and reports them one cycle after startOfFrame.
module asteroid_collision_detect
  import asteroid_collision_detect_pkg::*;
#(
  parameter int OBJ_W   = OBJECT_WIDTH,
  parameter int OBJ_H   = OBJECT_HEIGHT,
  parameter int MARGIN  = EDGE_MARGIN,
  parameter int CNT_W   = COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             startOfFrame,
  input  logic             enable,
  input  coord_t           pixelX,
  input  coord_t           pixelY,
  input  coord_t           topLeftX,
  input  coord_t           topLeftY,
  input  logic             asteroidDR,
  input  logic             playerDR,
  input  logic             missileDR,
  input  logic             borderDR,
  output logic             player_collision,
  output logic             missile_hit,
  output logic             border_collision,
  output logic [3:0]       HitEdgeCode,
  output logic [CNT_W-1:0] hitCount
);

  coord_t           offX;
  coord_t           offY;
  logic [3:0]       edgeCode;
  hit_t             cur;
  hit_t             acc_q, acc_d;
  hit_t             snap_q;
  logic [0:0]       state_q, state_d;
  logic [3:0]       edge_q;
  logic [CNT_W-1:0] cnt_q;
  logic             report;

  assign offX = pixelX - topLeftX;
  assign offY = pixelY - topLeftY;

  asteroid_edge_classifier #(
    .W (OBJ_W),
    .H (OBJ_H),
    .M (MARGIN)
  ) u_edge (
    .offX_i (offX),
    .offY_i (offY),
    .edge_o (edgeCode)
  );

  // this cycle's overlaps; same-cycle SOF hits go to the new frame
  always_comb begin
    cur.p   = asteroidDR & playerDR;
    cur.m   = asteroidDR & missileDR;
    cur.b   = asteroidDR & borderDR;
    cur.e   = (asteroidDR & borderDR) ? edgeCode : 4'b0000;
    state_d = startOfFrame ? REPORT : COLLECT;
    if (!enable)
      acc_d = '0;
    else if (startOfFrame)
      acc_d = cur;
    else
      acc_d = hit_t'(acc_q | cur);
  end

  // FSM, accumulators and frame snapshot
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= COLLECT;
      acc_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (startOfFrame)
        snap_q <= acc_q;
    end
  end

  assign report = (state_q == REPORT);

  assign player_collision = report & snap_q.p;
  assign missile_hit      = report & snap_q.m;
  assign border_collision = report & snap_q.b;

  // edge code held between reports; saturating hit counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      edge_q <= 4'b0000;
      cnt_q  <= '0;
    end else begin
      if (report)
        edge_q <= snap_q.e;
      if (missile_hit && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign HitEdgeCode = edge_q;
  assign hitCount    = cnt_q;

endmodule
